// File: rtl/stage_writeback_if.sv
interface stage_writeback_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_req_ready,
    input  dmem_resp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_req_ready,
    output dmem_resp_valid,
    output dmem_rdata
  );
endinterface

// File: rtl/stage_writeback.sv
module stage_writeback #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validM,
  input  logic               mem_accessM,
  input  logic               mem_writeM,
  input  logic [2:0]         funct3M,
  input  logic [XLEN-1:0]    alu_outM,
  input  logic [XLEN-1:0]    rs2M,
  input  logic [XLEN-1:0]    pc_plus4M,
  input  logic [4:0]         rdM,
  input  logic               reg_writeM,
  input  logic [1:0]         wb_selM,
  output logic               stallM,
  stage_writeback_if.master  dmem,
  output logic               reg_writeW,
  output logic [4:0]         rdW,
  output logic [XLEN-1:0]    wb_resultW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lo_q, lo_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            stall_c;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_we        = we_q;
  assign dmem.dmem_addr      = addr_q;
  assign dmem.dmem_wdata     = wdata_q;
  assign dmem.dmem_wstrb     = wstrb_q;

  // stall is held low while reset is asserted so every output reads 0 in reset
  assign stallM     = stall_c & rst;
  assign reg_writeW = reg_write_q;
  assign rdW        = rd_q;
  assign wb_resultW = result_q;

  always_comb begin
    ld_byte   = '0;
    ld_half   = '0;
    load_data = '0;
    case (lo_q)
      2'd0:    ld_byte = dmem.dmem_rdata[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      default: ld_byte = dmem.dmem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    funct3_d = funct3_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (validM & mem_accessM) begin
          state_d  = REQ;
          stall_c  = 1'b1;
          addr_d   = {alu_outM[XLEN-1:2], 2'b00};
          we_d     = mem_writeM;
          funct3_d = funct3M;
          lo_d     = alu_outM[1:0];
          wstrb_d  = '0;
          wdata_d  = '0;
          if (mem_writeM) begin
            case (funct3M[1:0])
              2'b00: begin
                wstrb_d = 4'b0001 << alu_outM[1:0];
                wdata_d = {(XLEN/8){rs2M[7:0]}};
              end
              2'b01: begin
                wstrb_d = 4'b0011 << {alu_outM[1], 1'b0};
                wdata_d = {(XLEN/16){rs2M[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = rs2M;
              end
            endcase
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem.dmem_req_ready) begin
          if (we_q) begin
            state_d = IDLE;
            stall_c = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (dmem.dmem_resp_valid) begin
          state_d = IDLE;
          stall_c = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    result_d    = result_q;
    if (!stallM) begin
      reg_write_d = validM & reg_writeM & (rdM != '0) & ~(mem_accessM & mem_writeM);
      rd_d        = rdM;
      case (wb_selM)
        2'b00:   result_d = alu_outM;
        2'b01:   result_d = load_data;
        2'b10:   result_d = pc_plus4M;
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      lo_q        <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      lo_q        <= lo_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
    end
  end

endmodule
